sdbp_frame_tx: RTL

- Sits directly downstream of the LED brightness write-stream generator, which produces sdbpflag/wtaddr/wtdina at 25 MHz.
- Captures each 360-word brightness frame into a double-buffered 360x16 RAM.
- Shifts the frame serially (MSB first) to the MiniLED driver chain and issues a latch pulse.
- Decouples the periodic write window from the slower serial transmission so a frame is never sent half-updated.

---
 rtl/sdbp_frame_tx.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdbp_frame_tx.sv
// ---------------------------------------------------------------------------
// sdbp_frame_tx
//
// Captures one brightness frame (NUM_LED words of DATA_W bits) from the
// upstream write stream into a double-buffered RAM. It then shifts the frame
// MSB-first to the MiniLED driver chain and finishes with a latch pulse.
// The write bank and the read bank swap only on a completed capture, so the
// transmitter never sees a half-updated frame.
//
// Optional feature: define SDBP_TX_CHECKSUM_EN to append one extra word after
// the last data word. That word is the modulo-2^DATA_W sum of all data words.
//
// Ports:
//   clk         system clock (25 MHz)
//   rst_n       asynchronous active-low reset
//   sdbpflag    frame-start flag; a rising edge opens the capture window
//   wtaddr      write address, 1..NUM_LED maps to RAM index wtaddr-1
//   wtdina      brightness word paired with wtaddr
//   sclk        serial clock to the driver, idles low
//   sdo         serial data, changes only while sclk is low
//   le          latch enable, LATCH_W cycles after the last bit
//   busy        high from TX start until le falls
//   frame_done  one-cycle pulse on the cycle le falls
//   frame_drop  one-cycle pulse when a pending frame is overwritten unsent
// ---------------------------------------------------------------------------
module sdbp_frame_tx #(
  parameter int NUM_LED = 360,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int LATCH_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdbpflag,
  input  logic [9:0]        wtaddr,
  input  logic [DATA_W-1:0] wtdina,
  output logic              sclk,
  output logic              sdo,
  output logic              le,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_drop
);

  localparam int AW = $clog2(2 * NUM_LED);
  localparam int IW = $clog2(NUM_LED + 2);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(LATCH_W + 1);
`ifdef SDBP_TX_CHECKSUM_EN
  localparam int LAST_WORD = NUM_LED;
  localparam logic [IW-1:0] LAST_DATA_I = IW'(NUM_LED - 1);
`else
  localparam int LAST_WORD = NUM_LED - 1;
`endif
  localparam logic [9:0]    NUM_LED_A = 10'(NUM_LED);
  localparam logic [IW-1:0] NUM_LED_I = IW'(NUM_LED);
  localparam logic [IW-1:0] LAST_I    = IW'(LAST_WORD);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_W - 1);
  localparam logic [AW-1:0] BANK_OFS  = AW'(NUM_LED);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } tx_state_e;

  // Both banks share one array: bank b occupies [b*NUM_LED +: NUM_LED].
  logic [DATA_W-1:0] mem_r [0:2*NUM_LED-1];
  logic [DATA_W-1:0] rd_data_r;

  logic              sdbpflag_d_r;
  logic              cap_open_r;
  logic              cap_wrote_r;
  logic              bank_sel_r;     // bank currently being written
  logic              pending_r;
  logic              start_r;
  logic              frame_drop_r;

  tx_state_e         state_r;
  logic [IW-1:0]     word_idx_r;
  logic [IW-1:0]     rd_idx_r;
  logic [BW-1:0]     bit_idx_r;
  logic [DW-1:0]     div_cnt_r;
  logic [LW-1:0]     lat_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic              sclk_r;
  logic              sdo_r;
  logic              le_r;
  logic              busy_r;
  logic              frame_done_r;
`ifdef SDBP_TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  logic              rise_s;
  logic              in_range_s;
  logic              wr_en_s;
  logic              capture_done_s;
  logic              cap_busy_s;
  logic              tx_idle_s;
  logic              swap_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     rd_addr_s;
  logic [DATA_W-1:0] next_word_s;

  // Capture-window decode and the bank-swap decision.
  always_comb begin
    rise_s         = sdbpflag & ~sdbpflag_d_r;
    in_range_s     = (wtaddr != 10'd0) && (wtaddr <= NUM_LED_A);
    wr_en_s        = cap_open_r && in_range_s;
    capture_done_s = cap_open_r && cap_wrote_r && (wtaddr == 10'd0);
    // A partly rewritten write bank must not be swapped in. Blocking the
    // swap while a capture is under way keeps a pending swap from handing
    // a half-updated frame to the transmitter.
    cap_busy_s     = cap_open_r && (cap_wrote_r || wr_en_s);
    // start_r counts as busy: a start has already been committed.
    tx_idle_s      = (state_r == ST_IDLE) && !start_r;
    swap_s         = tx_idle_s && (capture_done_s || (pending_r && !cap_busy_s));
    wr_addr_s      = (bank_sel_r ? BANK_OFS : {AW{1'b0}}) + AW'(wtaddr - 10'd1);
    // Reads past the last data word (checksum slot) are clamped; the value
    // is never used.
    rd_addr_s      = (bank_sel_r ? {AW{1'b0}} : BANK_OFS)
                   + ((rd_idx_r < NUM_LED_I) ? AW'(rd_idx_r) : {AW{1'b0}});
  end

  // Pick the word that follows the one now shifting out.
  always_comb begin
`ifdef SDBP_TX_CHECKSUM_EN
    if (word_idx_r == LAST_DATA_I) begin
      next_word_s = csum_r;
    end else begin
      next_word_s = rd_data_r;
    end
`else
    next_word_s = rd_data_r;
`endif
  end

  // Frame RAM: one write port (capture) and one registered read port (TX).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wtdina;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Capture window, bank select, pending flag and the TX start request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdbpflag_d_r <= 1'b0;
      cap_open_r   <= 1'b0;
      cap_wrote_r  <= 1'b0;
      bank_sel_r   <= 1'b0;
      pending_r    <= 1'b0;
      start_r      <= 1'b0;
      frame_drop_r <= 1'b0;
    end else begin
      sdbpflag_d_r <= sdbpflag;
      start_r      <= swap_s;
      // A second capture on top of an unsent pending frame replaces it.
      frame_drop_r <= capture_done_s && pending_r;

      if (swap_s) begin
        bank_sel_r <= ~bank_sel_r;
      end else begin
        bank_sel_r <= bank_sel_r;
      end

      if (swap_s) begin
        pending_r <= 1'b0;
      end else if (capture_done_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end

      if (rise_s) begin
        // A restart keeps already written words; they are overwritten in place.
        cap_open_r  <= 1'b1;
        cap_wrote_r <= 1'b0;
      end else if (capture_done_s) begin
        cap_open_r  <= 1'b0;
        cap_wrote_r <= 1'b0;
      end else if (wr_en_s) begin
        cap_open_r  <= cap_open_r;
        cap_wrote_r <= 1'b1;
      end else begin
        cap_open_r  <= cap_open_r;
        cap_wrote_r <= cap_wrote_r;
      end
    end
  end

  // Serial transmit FSM: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      word_idx_r   <= {IW{1'b0}};
      rd_idx_r     <= {IW{1'b0}};
      bit_idx_r    <= {BW{1'b0}};
      div_cnt_r    <= {DW{1'b0}};
      lat_cnt_r    <= {LW{1'b0}};
      shreg_r      <= {DATA_W{1'b0}};
      sclk_r       <= 1'b0;
      sdo_r        <= 1'b0;
      le_r         <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef SDBP_TX_CHECKSUM_EN
      csum_r       <= {DATA_W{1'b0}};
`endif
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Address 0 is presented while start_r is high, so word 0 is
          // already in rd_data_r during LOAD.
          rd_idx_r   <= {IW{1'b0}};
          word_idx_r <= {IW{1'b0}};
          sclk_r     <= 1'b0;
          sdo_r      <= 1'b0;
          le_r       <= 1'b0;
          if (start_r) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          shreg_r    <= rd_data_r;
          sdo_r      <= rd_data_r[DATA_W-1];
          sclk_r     <= 1'b0;
          bit_idx_r  <= {BW{1'b0}};
          div_cnt_r  <= {DW{1'b0}};
          word_idx_r <= {IW{1'b0}};
          rd_idx_r   <= IW'(1);     // prefetch word 1
`ifdef SDBP_TX_CHECKSUM_EN
          csum_r     <= rd_data_r;
`endif
          state_r    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end else begin
            div_cnt_r <= {DW{1'b0}};
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else begin
              // End of the high phase: sclk falls and data may advance.
              sclk_r <= 1'b0;
              if (bit_idx_r != BIT_LAST) begin
                bit_idx_r <= bit_idx_r + BW'(1);
                shreg_r   <= shreg_r << 1;
                sdo_r     <= shreg_r[DATA_W-2];
              end else if (word_idx_r == LAST_I) begin
                state_r   <= ST_LATCH;
                sdo_r     <= 1'b0;
                le_r      <= 1'b1;
                lat_cnt_r <= {LW{1'b0}};
              end else begin
                // Next word was prefetched, so sclk runs on without a gap.
                bit_idx_r  <= {BW{1'b0}};
                word_idx_r <= word_idx_r + IW'(1);
                rd_idx_r   <= rd_idx_r + IW'(1);
                shreg_r    <= next_word_s;
                sdo_r      <= next_word_s[DATA_W-1];
`ifdef SDBP_TX_CHECKSUM_EN
                if (word_idx_r != LAST_DATA_I) begin
                  csum_r <= csum_r + rd_data_r;
                end else begin
                  csum_r <= csum_r;
                end
`endif
              end
            end
          end
        end
        ST_LATCH: begin
          if (lat_cnt_r == LAT_LAST) begin
            state_r      <= ST_IDLE;
            le_r         <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            lat_cnt_r <= lat_cnt_r + LW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          sdo_r   <= 1'b0;
          le_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk       = sclk_r;
  assign sdo        = sdo_r;
  assign le         = le_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign frame_drop = frame_drop_r;

endmodule
